// File: rtl/ram_boot_loader_pkg.sv
// ============================================================================
// ram_boot_loader_pkg
//   Shared types and constants for the RAM boot loader.
//   - state_t         : loader state encoding
//   - AW_DEFAULT      : default address width
//   - DW_DEFAULT      : default data word width
//   - BYTES_PER_WORD  : image bytes per RAM word (high byte first)
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_boot_loader_pkg;

  localparam int AW_DEFAULT     = 16;
  localparam int DW_DEFAULT     = 16;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DAT_HI = 3'd3,
    DAT_LO = 3'd4,
    FLUSH  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_port_mux.sv
// ============================================================================
// ram_port_mux
//   Combinational select of the RAM port between the boot loader and the CPU.
//   Ports:
//     load_done             : 1 selects the CPU, 0 selects the loader
//     ld_addr/ld_data/ld_wren           : loader write port
//     cpu_maddr/cpu_data_o/cpu_wr       : CPU memory port
//     address/data/wren                 : to the RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_port_mux
  import ram_boot_loader_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          load_done,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_wren,
  input  logic [AW-1:0] cpu_maddr,
  input  logic [DW-1:0] cpu_data_o,
  input  logic          cpu_wr,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data,
  output logic          wren
);

  // CPU writes are blocked entirely until the image is in place.
  assign address = load_done ? cpu_maddr  : ld_addr;
  assign data    = load_done ? cpu_data_o : ld_data;
  assign wren    = load_done ? cpu_wr     : ld_wren;

endmodule

`default_nettype wire

// File: rtl/ram_boot_loader.sv
// ============================================================================
// ram_boot_loader
//   Holds the CPU in reset while a byte-stream program image is written into
//   RAM as 16-bit words from BASE_ADDR upward, then releases the CPU and
//   passes its memory port straight through to the RAM.
//   Image format: LEN_HI, LEN_LO, then LEN words, high byte first.
//   Ports:
//     CLK, RST (async, active-low)
//     LOAD_EN                      : 1 = load image, 0 = skip load
//     BYTE_IN/BYTE_VALID/BYTE_READY: image byte stream handshake
//     CPU_MADDR/CPU_DATA_O/CPU_WR  : CPU memory port
//     CPU_RST                      : active-low CPU reset
//     ADDRESS/DATA/WREN            : RAM port
//     LOAD_DONE/LOAD_ERR           : status
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int            AW        = AW_DEFAULT,
  parameter int            DW        = DW_DEFAULT,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter logic [15:0]   MAX_WORDS = 16'd4096
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LOAD_EN,
  input  logic [7:0]    BYTE_IN,
  input  logic          BYTE_VALID,
  output logic          BYTE_READY,
  input  logic [AW-1:0] CPU_MADDR,
  input  logic [DW-1:0] CPU_DATA_O,
  input  logic          CPU_WR,
  output logic          CPU_RST,
  output logic [AW-1:0] ADDRESS,
  output logic [DW-1:0] DATA,
  output logic          WREN,
  output logic          LOAD_DONE,
  output logic          LOAD_ERR
);

  state_t                       state;
  logic [7:0]                   len_hi_byte;
  logic [DW/BYTES_PER_WORD-1:0] dat_hi_byte;
  logic [15:0]                  word_count;
  logic [15:0]                  index;
  logic [AW-1:0]                ld_addr;
  logic [DW-1:0]                ld_data;
  logic                         ld_wren;

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] index_next;

  assign xfer       = BYTE_VALID & BYTE_READY;
  assign len_full   = {len_hi_byte, BYTE_IN};
  assign index_next = index + 16'd1;

  // BYTE_READY, CPU_RST, LOAD_DONE and LOAD_ERR are registered alongside the
  // state so each takes its new value on the first cycle of the new state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= BOOT;
      BYTE_READY  <= 1'b0;
      CPU_RST     <= 1'b0;
      LOAD_DONE   <= 1'b0;
      LOAD_ERR    <= 1'b0;
      len_hi_byte <= '0;
      dat_hi_byte <= '0;
      word_count  <= '0;
      index       <= '0;
      ld_addr     <= BASE_ADDR;
      ld_data     <= '0;
      ld_wren     <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse following the low-byte accept.
      ld_wren <= 1'b0;
      case (state)
        BOOT: begin
          if (LOAD_EN) begin
            state      <= LEN_HI;
            BYTE_READY <= 1'b1;
          end else begin
            state     <= DONE;
            CPU_RST   <= 1'b1;
            LOAD_DONE <= 1'b1;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_hi_byte <= BYTE_IN;
            state       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            word_count <= len_full;
            if (len_full == 16'd0) begin
              state      <= DONE;
              BYTE_READY <= 1'b0;
              CPU_RST    <= 1'b1;
              LOAD_DONE  <= 1'b1;
            end else if (len_full > MAX_WORDS) begin
              state      <= ERR;
              BYTE_READY <= 1'b0;
              LOAD_ERR   <= 1'b1;
            end else begin
              state <= DAT_HI;
            end
          end
        end
        DAT_HI: begin
          if (xfer) begin
            dat_hi_byte <= BYTE_IN;
            state       <= DAT_LO;
          end
        end
        DAT_LO: begin
          if (xfer) begin
            ld_data <= {dat_hi_byte, BYTE_IN};
            // Address wraps modulo 2^AW; only the length check guards range.
            ld_addr <= BASE_ADDR + AW'(index);
            ld_wren <= 1'b1;
            index   <= index_next;
            if (index_next == word_count) begin
              state      <= FLUSH;
              BYTE_READY <= 1'b0;
            end else begin
              state <= DAT_HI;
            end
          end
        end
        FLUSH: begin
          state     <= DONE;
          CPU_RST   <= 1'b1;
          LOAD_DONE <= 1'b1;
        end
        DONE: state <= DONE;
        ERR:  state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

  ram_port_mux #(
    .AW(AW),
    .DW(DW)
  ) u_ram_port_mux (
    .load_done (LOAD_DONE),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_wren   (ld_wren),
    .cpu_maddr (CPU_MADDR),
    .cpu_data_o(CPU_DATA_O),
    .cpu_wr    (CPU_WR),
    .address   (ADDRESS),
    .data      (DATA),
    .wren      (WREN)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_boot_loader.sv
// ============================================================================
// tb_ram_boot_loader
//   Scoreboard bench: expected RAM writes are queued as stimulus is issued and
//   a monitor process pops and compares on every WREN cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_boot_loader;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          LOAD_EN = 1'b0;
  logic [7:0]    BYTE_IN = 8'h00;
  logic          BYTE_VALID = 1'b0;
  logic          BYTE_READY;
  logic [AW-1:0] CPU_MADDR = '0;
  logic [DW-1:0] CPU_DATA_O = '0;
  logic          CPU_WR = 1'b0;
  logic          CPU_RST;
  logic [AW-1:0] ADDRESS;
  logic [DW-1:0] DATA;
  logic          WREN;
  logic          LOAD_DONE;
  logic          LOAD_ERR;

  ram_boot_loader #(
    .AW(AW), .DW(DW), .BASE_ADDR(16'h0000), .MAX_WORDS(16'd4)
  ) dut (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .CPU_MADDR(CPU_MADDR), .CPU_DATA_O(CPU_DATA_O), .CPU_WR(CPU_WR),
    .CPU_RST(CPU_RST), .ADDRESS(ADDRESS), .DATA(DATA), .WREN(WREN),
    .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port RAM driven by the DUT.
  logic [15:0] mem [0:65535];
  always @(posedge CLK) if (WREN) mem[ADDRESS] <= DATA;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (WREN !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wr_unexpected: got wren=%b addr %h data %h expected no write", WREN, ADDRESS, DATA);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(ADDRESS), 32'(e[31:16]));
          chk("wr_data", 32'(DATA), 32'(e[15:0]));
        end
      end
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // Called just after a posedge; returns just after the posedge of transfer.
  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    int t;
    ok = 1'b0;
    t  = 0;
    repeat (gap) begin
      BYTE_IN = 8'hEE;
      @(posedge CLK); #1;
    end
    BYTE_IN    = b;
    BYTE_VALID = 1'b1;
    while (!ok && t < 20) begin
      @(negedge CLK);
      if (BYTE_READY === 1'b1) ok = 1'b1;
      @(posedge CLK); #1;
      t++;
    end
    BYTE_VALID = 1'b0;
    BYTE_IN    = 8'h5A;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout: byte %h not accepted after %0d cycles, required acceptance", b, t);
    end
  endtask

  task automatic send_seq(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send(bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  // Asserts reset away from clock edges, checks reset outputs, releases, and
  // returns just after the posedge on which BOOT is evaluated.
  task automatic do_reset(input logic le);
    @(negedge CLK); #1;
    RST       = 1'b0;
    LOAD_EN   = le;
    CPU_WR    = 1'b0;
    CPU_MADDR = 16'hFFFF;
    CPU_DATA_O = 16'hFFFF;
    @(negedge CLK);
    chk("rst_byte_ready", 32'(BYTE_READY), 32'd0);
    chk("rst_cpu_rst",    32'(CPU_RST),    32'd0);
    chk("rst_load_done",  32'(LOAD_DONE),  32'd0);
    chk("rst_load_err",   32'(LOAD_ERR),   32'd0);
    chk("rst_wren",       32'(WREN),       32'd0);
    chk("rst_address",    32'(ADDRESS),    32'h0000);
    chk("rst_data",       32'(DATA),       32'h0000);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  // After the last byte: one FLUSH cycle, then DONE with the CPU released.
  task automatic check_finish(input string tag);
    @(negedge CLK);
    chk({tag, "_flush_cpu_rst"}, 32'(CPU_RST), 32'd0);
    chk({tag, "_flush_ready"},   32'(BYTE_READY), 32'd0);
    @(negedge CLK);
    chk({tag, "_done_cpu_rst"},  32'(CPU_RST), 32'd1);
    chk({tag, "_load_done"},     32'(LOAD_DONE), 32'd1);
    chk({tag, "_load_err"},      32'(LOAD_ERR), 32'd0);
    chk({tag, "_q_empty"},       32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] img3[$];
    img3 = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h7F};
    fork monitor(); join_none

    // 1: three words, no gaps
    do_reset(1'b1);
    expect_wr(16'h0000, 16'h1234);
    expect_wr(16'h0001, 16'hABCD);
    expect_wr(16'h0002, 16'h007F);
    send_seq(img3, 0);
    check_finish("img3");
    chk("ram0", 32'(mem[0]), 32'h1234);
    chk("ram1", 32'(mem[1]), 32'hABCD);
    chk("ram2", 32'(mem[2]), 32'h007F);
    CPU_MADDR = 16'h4321; CPU_DATA_O = 16'h9999; CPU_WR = 1'b0;
    #1;
    chk("done_mux_addr", 32'(ADDRESS), 32'h4321);
    chk("done_mux_data", 32'(DATA), 32'h9999);

    // 2: same image with random idle gaps
    do_reset(1'b1);
    expect_wr(16'h0000, 16'h1234);
    expect_wr(16'h0001, 16'hABCD);
    expect_wr(16'h0002, 16'h007F);
    send_seq(img3, 5);
    check_finish("gaps");

    // 3: zero-length header goes straight to DONE
    do_reset(1'b1);
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge CLK);
    chk("zero_cpu_rst",   32'(CPU_RST), 32'd1);
    chk("zero_load_done", 32'(LOAD_DONE), 32'd1);
    chk("zero_ready",     32'(BYTE_READY), 32'd0);

    // 4: length above MAX_WORDS -> ERR, no writes even with CPU_WR asserted
    do_reset(1'b1);
    send(8'h00, 0);
    send(8'h05, 0);
    @(negedge CLK);
    chk("err_load_err",  32'(LOAD_ERR), 32'd1);
    chk("err_cpu_rst",   32'(CPU_RST), 32'd0);
    chk("err_load_done", 32'(LOAD_DONE), 32'd0);
    BYTE_VALID = 1'b1; BYTE_IN = 8'h11; CPU_WR = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("err_ready", 32'(BYTE_READY), 32'd0);
      chk("err_wren",  32'(WREN), 32'd0);
    end
    BYTE_VALID = 1'b0; CPU_WR = 1'b0;

    // 5: length equal to MAX_WORDS is accepted
    do_reset(1'b1);
    expect_wr(16'h0000, 16'hA001);
    expect_wr(16'h0001, 16'hB002);
    expect_wr(16'h0002, 16'hC003);
    expect_wr(16'h0003, 16'hD004);
    send_seq('{8'h00, 8'h04, 8'hA0, 8'h01, 8'hB0, 8'h02, 8'hC0, 8'h03, 8'hD0, 8'h04}, 0);
    check_finish("max");
    chk("ram3", 32'(mem[3]), 32'hD004);

    // 6: skip load, CPU writes through
    do_reset(1'b0);
    @(negedge CLK);
    chk("skip_cpu_rst",   32'(CPU_RST), 32'd1);
    chk("skip_load_done", 32'(LOAD_DONE), 32'd1);
    #1;
    CPU_MADDR = 16'h0010; CPU_DATA_O = 16'hBEEF; CPU_WR = 1'b1;
    expect_wr(16'h0010, 16'hBEEF);
    @(negedge CLK); #1;
    CPU_WR = 1'b0;
    @(negedge CLK);
    chk("ram10", 32'(mem[16'h0010]), 32'h0000BEEF);

    // 7: reset mid-load, then a fresh one-word image
    do_reset(1'b1);
    expect_wr(16'h0000, 16'h1111);
    expect_wr(16'h0001, 16'h2222);
    send_seq('{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22}, 0);
    do_reset(1'b1);
    chk("midrst_q_empty", 32'(exp_q.size()), 32'd0);
    expect_wr(16'h0000, 16'h55AA);
    send_seq('{8'h00, 8'h01, 8'h55, 8'hAA}, 0);
    check_finish("reload");
    chk("ram0_reload", 32'(mem[0]), 32'h55AA);

    repeat (3) @(negedge CLK);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_boot_loader.md
Name: ram_boot_loader

Overview:
- Sits between the CPU memory port and the single-port synchronous RAM.
- After reset it holds the CPU in reset, receives a program image as a byte stream, and writes it as 16-bit words into RAM from BASE_ADDR upward.
- When the load completes it releases the CPU and becomes a transparent pass-through of the CPU address, write-data and write-enable onto the RAM.

Parameters:
- AW, 16, address width (CPU MADDR and RAM ADDRESS).
- DW, 16, data word width; fixed at 2 bytes per word.
- BASE_ADDR, 16'h0000, RAM address of the first loaded word.
- MAX_WORDS, 16'd4096, largest accepted image length in words.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- LOAD_EN  in  1  sampled in BOOT: 1 = load an image, 0 = skip the load and release the CPU.
- BYTE_IN  in  8  image byte.
- BYTE_VALID  in  1  BYTE_IN is valid.
- BYTE_READY  out  1  loader accepts a byte this cycle; transfer occurs when BYTE_VALID and BYTE_READY are both 1.
- CPU_MADDR  in  AW  CPU memory address.
- CPU_DATA_O  in  DW  CPU write data.
- CPU_WR  in  1  CPU write enable.
- CPU_RST  out  1  active-low reset to the CPU.
- ADDRESS  out  AW  to RAM ADDRESS.
- DATA  out  DW  to RAM DATA.
- WREN  out  1  to RAM WREN.
- LOAD_DONE  out  1  image loaded, or load skipped.
- LOAD_ERR  out  1  image length exceeds MAX_WORDS.

Behaviour:
- Reset (RST = 0, asynchronous):
  - State goes to BOOT.
  - CPU_RST = 0, BYTE_READY = 0, LOAD_DONE = 0, LOAD_ERR = 0.
  - Internal load registers are cleared: ld_wren = 0, ld_addr = BASE_ADDR, ld_data = 0, word count = 0, index = 0.
  - Reset mid-load discards all progress; a new image restarts from its header.
- Image format: LEN_HI, LEN_LO, then LEN words, each sent high byte first.
- States:
  - BOOT: one cycle. LOAD_EN = 1 goes to LEN_HI; LOAD_EN = 0 goes to DONE.
  - LEN_HI: BYTE_READY = 1; on transfer, latch the count high byte and go to LEN_LO.
  - LEN_LO: BYTE_READY = 1; on transfer, latch the count low byte, then:
    - count = 0 goes to DONE;
    - count > MAX_WORDS goes to ERR;
    - otherwise go to DAT_HI.
  - DAT_HI: BYTE_READY = 1; on transfer, latch the high byte and go to DAT_LO.
  - DAT_LO: BYTE_READY = 1; on transfer:
    - register ld_data = {hi, BYTE_IN} and ld_addr = BASE_ADDR + index;
    - pulse ld_wren for exactly the next cycle;
    - increment index;
    - go to FLUSH if this was the last word, else go to DAT_HI.
  - FLUSH: BYTE_READY = 0; one cycle in which the final write completes; then go to DONE.
  - DONE: BYTE_READY = 0, LOAD_DONE = 1, CPU_RST = 1 (registered, effective the first cycle in DONE). Absorbing until reset.
  - ERR: BYTE_READY = 0, LOAD_ERR = 1, CPU_RST stays 0, no RAM writes. Absorbing until reset.
- Write latency: a word is written to RAM on the cycle after its low byte is accepted.
  - Back-to-back bytes therefore give at most one write every 2 cycles; the next high byte may be accepted during the write cycle.
- BYTE_VALID gaps: any number of idle cycles is allowed between bytes; the state holds; BYTE_IN is ignored while BYTE_VALID = 0.
- RAM mux:
  - In DONE: ADDRESS = CPU_MADDR, DATA = CPU_DATA_O, WREN = CPU_WR, combinationally.
  - In all other states: ADDRESS = ld_addr, DATA = ld_data, WREN = ld_wren. CPU_WR is ignored.
- Address arithmetic: BASE_ADDR + index is taken modulo 2^AW and wraps silently.
  - The MAX_WORDS check is the only length guard.
  - count == MAX_WORDS is accepted.
- Bytes offered in DONE, ERR or FLUSH are not accepted, because BYTE_READY = 0.

Decomposition:
- Shared package holds:
  - the state enum: BOOT, LEN_HI, LEN_LO, DAT_HI, DAT_LO, FLUSH, DONE, ERR;
  - AW and DW defaults;
  - the BYTES_PER_WORD = 2 constant.
- One natural sub-module: ram_port_mux, the combinational loader/CPU select onto ADDRESS/DATA/WREN, keyed on LOAD_DONE.
- Everything else stays in ram_boot_loader.

Test Plan:
- Stream 00 03 12 34 AB CD 00 7F, no gaps, LOAD_EN = 1:
  - RAM[0] = 1234, RAM[1] = ABCD, RAM[2] = 007F;
  - exactly 3 WREN pulses;
  - CPU_RST rises one cycle after FLUSH;
  - LOAD_DONE = 1.
- Same stream with 0-5 random idle cycles between bytes → identical RAM contents, no extra WREN pulses, BYTE_VALID gaps tolerated.
- Header 00 00 → DONE directly after LEN_LO, zero RAM writes, CPU_RST = 1.
- MAX_WORDS = 4, header 00 05 → ERR, LOAD_ERR = 1, CPU_RST stays 0, BYTE_READY = 0, no WREN.
- LOAD_EN = 0 at reset release → DONE after BOOT; CPU_WR = 1 with CPU_MADDR = 0010, CPU_DATA_O = BEEF → RAM[0010] = BEEF.
- Assert RST after the second data word of a 3-word load, then resend the full image 00 01 55 AA → RAM[0] = 55AA, LOAD_DONE = 1.
